leading_run_scan_ctrl: RTL

Sequences the leading-bit-count datapath over a stream of packed words for the decode path. It loads words over a valid/ready input and scans each word MSB-first from a bit pointer. A full-word leading-run count of the current run polarity is taken each SCAN cycle. It emits one (polarity, length) token per run over a valid/ready output, handling runs that cross word boundaries and runs longer than the count width.

---
 rtl/leading_run_scan_ctrl_if.sv | 27 ++
 rtl/leading_run_scan_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/leading_run_scan_ctrl_if.sv
// Word-in / run-token-out handshake bundle for the leading-run scan controller.
// master drives words and token acceptance; slave is the controller.
interface leading_run_scan_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic [CNT_W-1:0]  out_run;
  logic              out_split;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_run, out_split, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_run, out_split, out_last
  );
endinterface

// File: rtl/leading_run_scan_ctrl.sv
// Scans packed words MSB-first and emits one (polarity, length) token per run,
// carrying runs across word boundaries and cutting runs at the count ceiling.
module leading_run_scan_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  leading_run_scan_ctrl_if.slave bus,
  output logic                   busy
);
  localparam int PTR_W = $clog2(WORD_W + 1);
  localparam logic [PTR_W-1:0] WORD_PTR = PTR_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {LOAD, SCAN, EMIT} state_t;

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [CNT_W-1:0]  acc_reg, acc_next;
  logic              run_bit_reg, run_bit_next;
  logic              run_active_reg, run_active_next;
  logic              last_word_reg, last_word_next;
  logic              out_valid_reg, out_valid_next;
  logic              out_bit_reg, out_bit_next;
  logic [CNT_W-1:0]  out_run_reg, out_run_next;
  logic              out_split_reg, out_split_next;
  logic              out_last_reg, out_last_next;

  // Word aligned so the scan position sits at the MSB; vacated bits are zero.
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] diff;
  logic              pol;
  logic [PTR_W-1:0]  lead_len;
  logic [PTR_W-1:0]  rem;
  logic [PTR_W-1:0]  n;
  logic [CNT_W:0]    sum;
  logic [CNT_W-1:0]  k;

  assign shifted = word_reg << ptr_reg;
  assign pol     = run_active_reg ? run_bit_reg : shifted[WORD_W-1];

  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_diff
    assign diff[gi] = shifted[gi] ^ pol;
  end

  // Leading-zero count of the mismatch vector is the run length from ptr.
  always_comb begin
    lead_len = WORD_PTR;
    for (int i = 0; i < WORD_W; i++) begin
      if (diff[i]) lead_len = PTR_W'(WORD_W - 1 - i);
    end
  end

  assign rem = WORD_PTR - ptr_reg;
  // Zero fill below the word can look like a match, so clamp to what remains.
  assign n   = (lead_len < rem) ? lead_len : rem;
  assign sum = {1'b0, acc_reg} + (CNT_W+1)'(n);
  assign k   = CNT_MAX - acc_reg;

  always_comb begin
    state_next      = state_reg;
    word_next       = word_reg;
    ptr_next        = ptr_reg;
    acc_next        = acc_reg;
    run_bit_next    = run_bit_reg;
    run_active_next = run_active_reg;
    last_word_next  = last_word_reg;
    out_valid_next  = out_valid_reg;
    out_bit_next    = out_bit_reg;
    out_run_next    = out_run_reg;
    out_split_next  = out_split_reg;
    out_last_next   = out_last_reg;

    case (state_reg)
      LOAD: begin
        if (bus.in_valid) begin
          word_next      = bus.in_data;
          last_word_next = bus.in_last;
          ptr_next       = '0;
          state_next     = SCAN;
        end
      end

      SCAN: begin
        run_bit_next    = pol;
        run_active_next = 1'b1;
        if (sum > {1'b0, CNT_MAX}) begin
          // Ceiling reached: cut here, keep the run open for the remainder.
          ptr_next       = ptr_reg + PTR_W'(k);
          acc_next       = '0;
          out_valid_next = 1'b1;
          out_bit_next   = pol;
          out_run_next   = CNT_MAX;
          out_split_next = 1'b1;
          out_last_next  = 1'b0;
          state_next     = EMIT;
        end else if (n < rem) begin
          ptr_next        = ptr_reg + n;
          acc_next        = '0;
          run_active_next = 1'b0;
          out_valid_next  = 1'b1;
          out_bit_next    = pol;
          out_run_next    = sum[CNT_W-1:0];
          out_split_next  = 1'b0;
          out_last_next   = 1'b0;
          state_next      = EMIT;
        end else begin
          acc_next = sum[CNT_W-1:0];
          ptr_next = WORD_PTR;
          if (last_word_reg) begin
            out_valid_next = 1'b1;
            out_bit_next   = pol;
            out_run_next   = sum[CNT_W-1:0];
            out_split_next = 1'b0;
            out_last_next  = 1'b1;
            state_next     = EMIT;
          end else begin
            state_next = LOAD;
          end
        end
      end

      EMIT: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          if (out_last_reg) begin
            ptr_next        = '0;
            acc_next        = '0;
            run_active_next = 1'b0;
            state_next      = LOAD;
          end else if (ptr_reg == WORD_PTR) begin
            state_next = LOAD;
          end else begin
            state_next = SCAN;
          end
        end
      end

      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= LOAD;
      word_reg       <= '0;
      ptr_reg        <= '0;
      acc_reg        <= '0;
      run_bit_reg    <= 1'b0;
      run_active_reg <= 1'b0;
      last_word_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_bit_reg    <= 1'b0;
      out_run_reg    <= '0;
      out_split_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_reg       <= word_next;
      ptr_reg        <= ptr_next;
      acc_reg        <= acc_next;
      run_bit_reg    <= run_bit_next;
      run_active_reg <= run_active_next;
      last_word_reg  <= last_word_next;
      out_valid_reg  <= out_valid_next;
      out_bit_reg    <= out_bit_next;
      out_run_reg    <= out_run_next;
      out_split_reg  <= out_split_next;
      out_last_reg   <= out_last_next;
    end
  end

  assign bus.in_ready  = (state_reg == LOAD) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_bit   = out_bit_reg;
  assign bus.out_run   = out_run_reg;
  assign bus.out_split = out_split_reg;
  assign bus.out_last  = out_last_reg;
  assign busy          = (state_reg != LOAD) || run_active_reg;
endmodule
